// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-side types and constants: machine width, bubble encoding,
// fetch FSM states and the IF/ID register payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and an idle
// cycle inserts a bubble while leaving the pc field untouched.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   stall,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.valid <= 1'b0;
      q.pc    <= '0;
      q.instr <= NOP;
    end else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP;
    end else if (stall) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end else begin
      q.valid <= 1'b0;
      q.instr <= NOP;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, one-at-a-time instruction-memory FSM with a one-entry skid
// buffer for responses that arrive while ID is stalled, feeding the IF/ID register.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic [XLEN-1:0] id_instr
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] skid, skid_next;
  logic [XLEN-1:0] target;
  logic            stall;
  logic            deliver;
  if_id_t          fetched;
  if_id_t          id_q;

  assign stall     = !pc_write || !if_id_write;
  assign target    = redirect_pc & ALIGN_MASK;
  assign imem_addr = pc & ALIGN_MASK;
  assign imem_req  = rst_n && (state == FETCH) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      skid  <= skid_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    skid_next     = skid;
    deliver       = 1'b0;
    fetched.valid = 1'b1;
    fetched.pc    = imem_addr;
    fetched.instr = imem_rdata;
    unique case (state)
      FETCH: begin
        if (flush)           pc_next    = target;
        else if (imem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (flush) begin
          pc_next    = target;
          state_next = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          if (stall) begin
            skid_next  = imem_rdata;
            state_next = HOLD;
          end else begin
            deliver    = 1'b1;
            pc_next    = imem_addr + XLEN'(4);
            state_next = FETCH;
          end
        end
      end
      // The stale response always ends DROP, even if a new flush lands with it,
      // since no further request can be outstanding.
      DROP: begin
        if (flush)       pc_next    = target;
        if (imem_rvalid) state_next = FETCH;
      end
      HOLD: begin
        fetched.instr = skid;
        if (flush) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (!stall) begin
          deliver    = 1'b1;
          pc_next    = imem_addr + XLEN'(4);
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .stall(stall),
    .load (deliver),
    .d    (fetched),
    .q    (id_q)
  );

  assign id_valid = id_q.valid;
  assign id_pc    = id_q.pc;
  assign id_instr = id_q.instr;
  assign id_pc4   = id_q.pc + XLEN'(4);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, reset-mid-request sequence,
// then randomized traffic against a transaction-level reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] N = 32'h0000_0013;
  localparam logic [31:0] A = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1, if_id_write = 1'b1, flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_instr;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_stage #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
    .flush(flush), .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_pc(id_pc),
    .id_pc4(id_pc4), .id_instr(id_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pw, iw, fl; logic [31:0] rp; bit rdy, rv; logic [31:0] rd;
    bit e_req; logic [31:0] e_addr; bit e_v; logic [31:0] e_pc, e_instr;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit req, input logic [31:0] addr,
                           input bit v, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, ".imem_req"}, 32'(imem_req), 32'(req));
    if (req) check({tag, ".imem_addr"}, imem_addr, addr);
    check({tag, ".id_valid"}, 32'(id_valid), 32'(v));
    check({tag, ".id_pc"}, id_pc, pc);
    check({tag, ".id_pc4"}, id_pc4, pc + 32'd4);
    check({tag, ".id_instr"}, id_instr, instr);
  endtask

  task automatic drive(input bit pw, input bit iw, input bit fl, input logic [31:0] rp,
                       input bit rdy, input bit rv, input logic [31:0] rd);
    @(negedge clk);
    pc_write = pw; if_id_write = iw; flush = fl; redirect_pc = rp;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  // Reference model: one request in flight at most, a pending-discard flag,
  // a one-entry skid buffer and the IF/ID contents.
  logic [31:0] m_pc, m_skid, m_idpc, m_idinstr;
  bit          m_out, m_drop, m_skv, m_idv;

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_drop = 0; m_skv = 0; m_skid = '0;
    m_idv = 0; m_idpc = 32'h0; m_idinstr = N;
  endtask

  task automatic model_step(input bit pw, input bit iw, input bit fl, input logic [31:0] rp,
                            input bit rdy, input bit rv, input logic [31:0] rd);
    bit stall, got;
    logic [31:0] gpc, ginstr;
    stall = !pw || !iw; got = 0; gpc = m_pc; ginstr = '0;
    if (m_skv) begin
      if (fl) begin m_skv = 0; m_pc = rp & ~32'd3; end
      else if (!stall) begin got = 1; ginstr = m_skid; m_skv = 0; m_pc += 4; end
    end else if (m_drop) begin
      if (fl) m_pc = rp & ~32'd3;
      if (rv) m_drop = 0;
    end else if (m_out) begin
      if (fl) begin m_pc = rp & ~32'd3; m_out = 0; m_drop = !rv; end
      else if (rv) begin
        m_out = 0;
        if (stall) begin m_skv = 1; m_skid = rd; end
        else begin got = 1; ginstr = rd; m_pc += 4; end
      end
    end else begin
      if (fl) m_pc = rp & ~32'd3;
      else if (rdy) m_out = 1;
    end
    if (fl) begin m_idv = 0; m_idinstr = N; end
    else if (stall) ;
    else if (got) begin m_idv = 1; m_idpc = gpc; m_idinstr = ginstr; end
    else begin m_idv = 0; m_idinstr = N; end
  endtask

  initial begin
    // pw iw fl rp rdy rv rd | req addr v pc instr
    tbl.push_back('{1,1,0,0,1,0,0,            1,32'h0,0,32'h0,N});
    tbl.push_back('{1,1,0,0,1,1,A,            0,32'h0,0,32'h0,N});
    tbl.push_back('{1,1,0,0,1,0,0,            1,32'h4,1,32'h0,A});
    tbl.push_back('{1,1,0,0,1,1,A|4,          0,32'h4,0,32'h0,N});
    tbl.push_back('{1,1,0,0,1,0,0,            1,32'h8,1,32'h4,A|4});
    tbl.push_back('{0,0,0,0,1,1,A|8,          0,32'h8,0,32'h4,N});
    tbl.push_back('{0,1,0,0,1,0,0,            0,32'h8,0,32'h4,N});
    tbl.push_back('{1,0,0,0,1,0,0,            0,32'h8,0,32'h4,N});
    tbl.push_back('{1,1,0,0,1,0,0,            0,32'h8,0,32'h4,N});
    tbl.push_back('{1,1,0,0,1,0,0,            1,32'hC,1,32'h8,A|8});
    tbl.push_back('{1,1,1,32'h100,1,0,0,      0,32'hC,0,32'h8,N});
    tbl.push_back('{1,1,0,0,1,0,0,            0,32'h100,0,32'h8,N});
    tbl.push_back('{1,1,0,0,1,1,32'hDEADBEEF, 0,32'h100,0,32'h8,N});
    tbl.push_back('{1,1,0,0,1,0,0,            1,32'h100,0,32'h8,N});
    tbl.push_back('{1,1,0,0,1,1,A|32'h100,    0,32'h100,0,32'h8,N});
    tbl.push_back('{1,1,0,0,1,0,0,            1,32'h104,1,32'h100,A|32'h100});
    tbl.push_back('{1,1,0,0,1,1,A|32'h104,    0,32'h104,0,32'h100,N});
    tbl.push_back('{0,0,1,32'hFFFF_FFFE,1,0,0,0,32'h108,1,32'h104,A|32'h104});
    tbl.push_back('{1,1,0,0,1,0,0,            1,32'hFFFF_FFFC,0,32'h104,N});
    tbl.push_back('{1,1,0,0,1,1,32'h12345678, 0,32'hFFFF_FFFC,0,32'h104,N});
    tbl.push_back('{1,1,0,0,0,0,0,            1,32'h0,1,32'hFFFF_FFFC,32'h12345678});
    tbl.push_back('{1,1,0,0,0,0,0,            1,32'h0,0,32'hFFFF_FFFC,N});

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    #1 check_all("reset", 0, 32'h0, 0, 32'h0, N);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      if (i != 0) @(negedge clk);
      pc_write = t.pw; if_id_write = t.iw; flush = t.fl; redirect_pc = t.rp;
      imem_ready = t.rdy; imem_rvalid = t.rv; imem_rdata = t.rd;
      #1 check_all($sformatf("vec%0d", i), t.e_req, t.e_addr, t.e_v, t.e_pc, t.e_instr);
    end

    // Reset asserted while a request is outstanding, stray response after release
    drive(1,1,0,0,1,0,0);                  // FETCH pc0 -> WAIT
    drive(1,1,0,0,0,1,32'h0BAD_0000);      // deliver {0}, pc 4
    drive(1,1,0,0,1,0,0);                  // FETCH pc4 -> WAIT
    check("pre_rst.id_valid", 32'(id_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 0, 32'h0, 0, 32'h0, N);
    drive(1,1,0,0,0,1,32'h5555_5555);
    rst_n = 1'b1;
    drive(1,1,0,0,0,1,32'h6666_6666);      // stray rvalid in FETCH
    check_all("post_rst", 1, 32'h0, 0, 32'h0, N);
    drive(1,1,0,0,1,0,0);
    check_all("post_rst2", 1, 32'h0, 0, 32'h0, N);
    drive(1,1,0,0,0,1,32'h7777_7777);
    drive(1,1,0,0,0,0,0);
    check_all("post_rst3", 1, 32'h4, 1, 32'h0, 32'h7777_7777);

    // Randomized traffic against the reference model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int unsigned c = 0; c < 4000; c++) begin
      bit pw, iw, fl, rdy, rv;
      logic [31:0] rp, rd;
      pw  = ($urandom_range(0, 5) != 0);
      iw  = ($urandom_range(0, 5) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      rv  = (m_out || m_drop) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      rd  = $urandom;
      drive(pw, iw, fl, rp, rdy, rv, rd);
      check_all("rand", !m_out && !m_drop && !m_skv && !fl, m_pc, m_idv, m_idpc, m_idinstr);
      model_step(pw, iw, fl, rp, rdy, rv, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Fetch-side consumer of the hazard-detection and branch-resolution control signals.
- Holds the PC and fetches one instruction at a time through a valid/ready instruction-memory port.
- Owns the IF/ID pipeline register, stalling it or flushing it as commanded by the ID/EX stages.
- Inserts NOP bubbles into ID whenever no fetched instruction is available.

Parameters:
- XLEN, 32: address and instruction width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_write  in  1  from hazard unit; 0 = stall, hold PC.
- if_id_write  in  1  from hazard unit; 0 = stall, hold IF/ID.
- flush  in  1  branch/jump taken in EX; squash the fetch and IF/ID contents.
- redirect_pc  in  XLEN  target PC, valid when flush=1.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address (word aligned).
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid; at most one response per accepted request.
- imem_rdata  in  XLEN  instruction word.
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  XLEN  PC of the IF/ID instruction.
- id_pc4  out  XLEN  id_pc+4, modulo 2^XLEN.
- id_instr  out  XLEN  instruction, or NOP_INSTR when id_valid=0.

Behaviour:
- Reset (async assert, sync deassert): pc=RESET_PC, state=FETCH, skid buffer empty.
- Reset output values: imem_req=0 while rst_n=0, id_valid=0, id_pc=0, id_pc4=4, id_instr=NOP_INSTR.
- stall = !pc_write || !if_id_write. Both inputs are treated jointly.
- imem_addr = {pc[XLEN-1:2],2'b00}. redirect_pc[1:0] is ignored.
- FSM states: FETCH, WAIT, DROP, HOLD.
- FETCH:
  - imem_req = !flush.
  - flush: pc<=redirect_pc, stay in FETCH.
  - imem_ready && imem_req: go to WAIT. pc is unchanged until the response arrives.
- WAIT (request outstanding):
  - flush: pc<=redirect_pc. If imem_rvalid the same cycle, discard the response and go to FETCH; otherwise go to DROP.
  - imem_rvalid && !stall: load IF/ID with {1,pc,rdata}, pc<=pc+4, go to FETCH.
  - imem_rvalid && stall: capture rdata in the skid buffer, go to HOLD.
- DROP: the next imem_rvalid is discarded, then go to FETCH. A flush while in DROP updates pc and stays in DROP.
- HOLD:
  - flush: discard the skid buffer, pc<=redirect_pc, go to FETCH.
  - !stall: load IF/ID from the skid buffer, pc<=pc+4, go to FETCH.
  - stall: hold.
- IF/ID register priority:
  1. flush: id_valid<=0, id_instr<=NOP_INSTR. Flush beats stall.
  2. stall: hold all fields.
  3. New instruction delivered this cycle: load it.
  4. Otherwise insert a bubble: id_valid<=0, id_instr<=NOP_INSTR; id_pc unchanged.
- Latency: minimum 2 cycles per instruction (FETCH then WAIT with same-cycle imem_ready and a 1-cycle rvalid). No prefetch.
- PC wrap: 32'hFFFF_FFFC+4 = 0 for both pc and id_pc4.
- imem_rvalid in FETCH is a protocol violation; the block ignores it.
- Reset asserted mid-request: all state clears immediately. A late response after reset is ignored because the FSM is in FETCH.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and NOP_INSTR constants.
  - fetch_state_t enum {FETCH,WAIT,DROP,HOLD}.
  - if_id_t struct {valid,pc,instr}.
- One natural sub-module, if_id_reg: IF/ID register with flush/stall/load/bubble priority. The FSM, PC and skid buffer stay in the top module.

Test Plan:
- Reset then free-run, with imem_ready=1 and 1-cycle rvalid returning addr^32'hA5A5_0000 -> id_pc steps 0,4,8 every 2 cycles. id_valid alternates 1 with a bubble; bubbles show NOP 0x13.
- rvalid while pc_write=if_id_write=0 for 3 cycles -> FSM goes to HOLD, IF/ID frozen. After release, the skid instruction appears in ID with the correct pc, and pc advances by 4.
- flush with redirect_pc=0x100 during WAIT, rvalid 2 cycles later -> response dropped, next imem_addr=0x100, id_valid=0 the cycle after flush.
- flush and stall in the same cycle, with IF/ID valid -> id_valid=0 and id_instr=0x13 (flush wins); pc=redirect_pc.
- redirect_pc=0xFFFF_FFFE -> imem_addr=0xFFFF_FFFC. Next fetch address 0x0000_0000; id_pc4=0.
- rst_n asserted while in WAIT with rvalid pending -> outputs at reset values asynchronously. Stray rvalid after deassert is ignored; first fetch is at RESET_PC.
